// File: rtl/ones_comp_div_seq_if.sv
// Start/done handshake and result bus between the ALU sequencer (master)
// and the one's-complement divider (slave).
interface ones_comp_div_seq_if;
    logic        start;
    logic [29:0] numer;
    logic [14:0] denom;
    logic        busy;
    logic        done;
    logic [14:0] quot;
    logic [14:0] remain;
    logic        div_zero;
    logic        overflow;

    modport master (
        output start, numer, denom,
        input  busy, done, quot, remain, div_zero, overflow
    );

    modport slave (
        input  start, numer, denom,
        output busy, done, quot, remain, div_zero, overflow
    );
endinterface

// File: rtl/ones_comp_div_seq.sv
// Multi-cycle restoring divider: 30-bit double-precision one's-complement numerator
// by 15-bit one's-complement denominator. Define DIV_EARLY_TERM_EN for 14-iteration small-|N| divides.
module ones_comp_div_seq #(
    parameter int ITERS = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ones_comp_div_seq_if.slave   bus
);
    localparam int MW = 14;
    localparam int NW = 2 * MW;
    localparam int CW = 5;

    typedef enum logic [2:0] {IDLE, CONV, DIV, SIGN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [14:0]     hi_reg, lo_reg, den_reg;
    logic [NW-1:0]   dvd_reg;
    logic [NW-1:0]   quo_reg;
    logic [MW-1:0]   rem_reg;
    logic [MW-1:0]   dmag_reg;
    logic            sn_reg;
    logic [CW-1:0]   cnt_reg;
    logic [14:0]     quot_reg, remain_reg;
    logic            dz_reg, ovf_reg;

    // Magnitude/sign extraction, used during CONV
    logic            hi_zero, lo_zero, d_zero, sn;
    logic [MW-1:0]   hi_mag, lo_mag, d_mag;
    logic [NW-1:0]   hi_ext, n_mag;
    logic [NW-1:0]   dvd_init;
    logic [CW-1:0]   cnt_init;

    always_comb begin
        hi_zero = (hi_reg == 15'h0000) || (hi_reg == 15'h7fff);
        lo_zero = (lo_reg == 15'h0000) || (lo_reg == 15'h7fff);
        hi_mag  = hi_reg[14] ? ~hi_reg[13:0] : hi_reg[13:0];
        lo_mag  = lo_reg[14] ? ~lo_reg[13:0] : lo_reg[13:0];
        d_mag   = den_reg[14] ? ~den_reg[13:0] : den_reg[13:0];
        d_zero  = (d_mag == '0);
        hi_ext  = {hi_mag, {MW{1'b0}}};
        // Mixed-sign words: the low word borrows from the high word's weight
        if (!hi_zero && !lo_zero && (hi_reg[14] != lo_reg[14]))
            n_mag = hi_ext - {{MW{1'b0}}, lo_mag};
        else
            n_mag = hi_ext + {{MW{1'b0}}, lo_mag};
        sn = hi_zero ? lo_reg[14] : hi_reg[14];
`ifdef DIV_EARLY_TERM_EN
        if (n_mag[NW-1:MW] == '0) begin
            dvd_init = {n_mag[MW-1:0], {MW{1'b0}}};
            cnt_init = CW'(MW - 1);
        end else begin
            dvd_init = n_mag;
            cnt_init = CW'(ITERS - 1);
        end
`else
        dvd_init = n_mag;
        cnt_init = CW'(ITERS - 1);
`endif
    end

    // One restoring step: 14-bit subtraction suffices because a kept
    // difference is always below |D|.
    logic [MW:0]     rem_shift;
    logic            take;
    logic [MW-1:0]   rem_new;

    always_comb begin
        rem_shift = {rem_reg, dvd_reg[NW-1]};
        take      = (rem_shift >= {1'b0, dmag_reg});
        rem_new   = take ? (rem_shift[MW-1:0] - dmag_reg) : rem_shift[MW-1:0];
    end

    // Sign application and saturation for the SIGN state
    logic            q_big, sq;
    logic [MW-1:0]   q_mag;
    logic [14:0]     quot_fin, remain_fin;

    always_comb begin
        q_big = (quo_reg[NW-1:MW] != '0);
        q_mag = q_big ? {MW{1'b1}} : quo_reg[MW-1:0];
        sq    = sn_reg ^ den_reg[14];
        if (dz_reg) begin
            quot_fin   = sq ? 15'o40000 : 15'o37777;
            remain_fin = 15'o00000;
        end else begin
            quot_fin   = sq ? {1'b1, ~q_mag} : {1'b0, q_mag};
            remain_fin = sn_reg ? {1'b1, ~rem_reg} : {1'b0, rem_reg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state_reg)
            IDLE: if (bus.start) state_next = CONV;
            CONV: begin
                bus.busy   = 1'b1;
                state_next = d_zero ? SIGN : DIV;
            end
            DIV: begin
                bus.busy = 1'b1;
                if (cnt_reg == '0) state_next = SIGN;
            end
            SIGN: begin
                bus.busy   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg     <= '0;
            lo_reg     <= '0;
            den_reg    <= '0;
            dvd_reg    <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
            dmag_reg   <= '0;
            sn_reg     <= 1'b0;
            cnt_reg    <= '0;
            quot_reg   <= '0;
            remain_reg <= '0;
            dz_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (bus.start) begin
                    hi_reg  <= bus.numer[29:15];
                    lo_reg  <= bus.numer[14:0];
                    den_reg <= bus.denom;
                end
                CONV: begin
                    dz_reg   <= d_zero;
                    ovf_reg  <= 1'b0;
                    dmag_reg <= d_mag;
                    sn_reg   <= sn;
                    rem_reg  <= '0;
                    quo_reg  <= '0;
                    dvd_reg  <= dvd_init;
                    cnt_reg  <= cnt_init;
                end
                DIV: begin
                    rem_reg <= rem_new;
                    dvd_reg <= {dvd_reg[NW-2:0], 1'b0};
                    quo_reg <= {quo_reg[NW-2:0], take};
                    cnt_reg <= cnt_reg - 1'b1;
                end
                SIGN: begin
                    quot_reg   <= quot_fin;
                    remain_reg <= remain_fin;
                    ovf_reg    <= q_big & ~dz_reg;
                end
                default: ;
            endcase
        end
    end

    assign bus.quot     = quot_reg;
    assign bus.remain   = remain_reg;
    assign bus.div_zero = dz_reg;
    assign bus.overflow = ovf_reg;
endmodule
